wb_write_arbiter: RTL and testbench

//  Drives the single register-file write port (wen/rd/wdata) from two sources:
//   - the in-order pipeline writeback stage;
//   - the multi-cycle multiply/divide unit (MDU) result channel.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_write_arbiter_scoreboard.sv | 44 ++++
 rtl/wb_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W     = 5;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_HOLD,
        WB_FORCE
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_write_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register owed by the MDU.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  busy_rs1_o,
    output logic                  busy_rs2_o,
    output logic [31:0]           busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Set is applied after clear so a re-issue to the register being retired stays owed.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_en_i && (set_rd_i != '0)) begin
            busy_d[set_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_rs1_o = (rs1_i != '0) & busy_q[rs1_i];
    assign busy_rs2_o = (rs2_i != '0) & busy_q[rs2_i];
    assign busy_o     = busy_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single regfile write port between pipeline WB and a one-entry MDU result buffer.
// Optional macro WB_FWD_EN adds same-cycle write-to-read forwarding on the ID operand outputs.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_wen_i,
    input  logic [REG_ADDR_W-1:0] pipe_rd_i,
    input  logic [XLEN-1:0]       pipe_wdata_i,
    output logic                  pipe_stall_o,
    input  logic                  mdu_issue_i,
    input  logic [REG_ADDR_W-1:0] mdu_issue_rd_i,
    input  logic                  mdu_valid_i,
    input  logic [REG_ADDR_W-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]       mdu_wdata_i,
    output logic                  mdu_ready_o,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  busy_rs1_o,
    output logic                  busy_rs2_o,
    input  logic [XLEN-1:0]       rf_rdata1_i,
    input  logic [XLEN-1:0]       rf_rdata2_i,
    output logic [XLEN-1:0]       rdata1_o,
    output logic [XLEN-1:0]       rdata2_o,
    output logic                  wen_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]       wdata_o
);

    localparam int              CNT_W     = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_MAX - 1);

    wb_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  buf_valid_q, buf_valid_d;
    logic [REG_ADDR_W-1:0] buf_rd_q, buf_rd_d;
    logic [XLEN-1:0]       buf_wdata_q, buf_wdata_d;

    logic        pipe_slot;
    logic        force_wr;
    logic        pipe_wr;
    logic        buf_wr;
    logic        mdu_accept;
    logic        sb_busy_rs1;
    logic        sb_busy_rs2;
    logic [31:0] busy_vec;

    assign pipe_slot  = pipe_wen_i & (pipe_rd_i != '0);
    assign force_wr   = (state_q == WB_FORCE);
    assign pipe_wr    = pipe_slot & ~force_wr;
    assign buf_wr     = buf_valid_q & (force_wr | ~pipe_slot);
    assign mdu_ready_o = ~reset & ~buf_valid_q;
    assign mdu_accept = mdu_valid_i & mdu_ready_o;
    assign pipe_stall_o = ~reset & force_wr;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        wen_o   = 1'b0;
        rd_o    = '0;
        wdata_o = '0;
        if (!reset) begin
            if (pipe_wr) begin
                wen_o   = 1'b1;
                rd_o    = pipe_rd_i;
                wdata_o = pipe_wdata_i;
            end else if (buf_wr) begin
                wen_o   = 1'b1;
                rd_o    = buf_rd_q;
                wdata_o = buf_wdata_q;
            end
        end
    end

    // The counter tracks consecutive cycles the buffered result lost to the pipeline;
    // reaching the limit steals exactly one slot in FORCE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WB_IDLE, WB_HOLD: begin
                if (buf_valid_q && pipe_slot) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc >= CNT_LIMIT) ? WB_FORCE : WB_HOLD;
                end else begin
                    cnt_d   = '0;
                    state_d = WB_IDLE;
                end
            end
            WB_FORCE: begin
                cnt_d   = '0;
                state_d = WB_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = WB_IDLE;
            end
        endcase
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_wdata_d = buf_wdata_q;
        if (buf_wr) begin
            buf_valid_d = 1'b0;
        end
        if (mdu_accept) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = mdu_rd_i;
            buf_wdata_d = mdu_wdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WB_IDLE;
            cnt_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    wb_scoreboard u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en_i   (mdu_issue_i),
        .set_rd_i   (mdu_issue_rd_i),
        .clr_en_i   (buf_wr & ~reset),
        .clr_rd_i   (buf_rd_q),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .busy_rs1_o (sb_busy_rs1),
        .busy_rs2_o (sb_busy_rs2),
        .busy_o     (busy_vec)
    );

    assign busy_rs1_o = ~reset & sb_busy_rs1;
    assign busy_rs2_o = ~reset & sb_busy_rs2;

`ifdef WB_FWD_EN
    assign rdata1_o = (wen_o && (rd_o == rs1_i) && (rs1_i != '0)) ? wdata_o : rf_rdata1_i;
    assign rdata2_o = (wen_o && (rd_o == rs2_i) && (rs2_i != '0)) ? wdata_o : rf_rdata2_i;
`else
    assign rdata1_o = rf_rdata1_i;
    assign rdata2_o = rf_rdata2_i;
`endif

    // ID must stall on a register the MDU still owes; a pipeline write there is a hazard bug.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(pipe_slot && busy_vec[pipe_rd_i]))
                else $error("pipeline write to register x%0d still owed by MDU", pipe_rd_i);
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected writes are queued, a negedge monitor checks them.
module tb_wb_write_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        stall;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_wen_i;
    logic [4:0]  pipe_rd_i;
    logic [63:0] pipe_wdata_i;
    logic        pipe_stall_o;
    logic        mdu_issue_i;
    logic [4:0]  mdu_issue_rd_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [63:0] mdu_wdata_i;
    logic        mdu_ready_o;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic        busy_rs1_o;
    logic        busy_rs2_o;
    logic [63:0] rf_rdata1_i;
    logic [63:0] rf_rdata2_i;
    logic [63:0] rdata1_o;
    logic [63:0] rdata2_o;
    logic        wen_o;
    logic [4:0]  rd_o;
    logic [63:0] wdata_o;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [63:0] fwd_expect;

    always #5 clock = ~clock;

    wb_write_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .pipe_wen_i     (pipe_wen_i),
        .pipe_rd_i      (pipe_rd_i),
        .pipe_wdata_i   (pipe_wdata_i),
        .pipe_stall_o   (pipe_stall_o),
        .mdu_issue_i    (mdu_issue_i),
        .mdu_issue_rd_i (mdu_issue_rd_i),
        .mdu_valid_i    (mdu_valid_i),
        .mdu_rd_i       (mdu_rd_i),
        .mdu_wdata_i    (mdu_wdata_i),
        .mdu_ready_o    (mdu_ready_o),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .busy_rs1_o     (busy_rs1_o),
        .busy_rs2_o     (busy_rs2_o),
        .rf_rdata1_i    (rf_rdata1_i),
        .rf_rdata2_i    (rf_rdata2_i),
        .rdata1_o       (rdata1_o),
        .rdata2_o       (rdata2_o),
        .wen_o          (wen_o),
        .rd_o           (rd_o),
        .wdata_o        (wdata_o)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pwen, input logic [4:0] prd, input logic [63:0] pdata,
                                 input logic mvalid, input logic [4:0] mrd, input logic [63:0] mdata,
                                 input logic iss, input logic [4:0] iss_rd);
        pipe_wen_i     = pwen;
        pipe_rd_i      = prd;
        pipe_wdata_i   = pdata;
        mdu_valid_i    = mvalid;
        mdu_rd_i       = mrd;
        mdu_wdata_i    = mdata;
        mdu_issue_i    = iss;
        mdu_issue_rd_i = iss_rd;
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [63:0] data, input logic stall);
        exp_t e;
        e.rd    = rd;
        e.data  = data;
        e.stall = stall;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Every regfile write the DUT makes out of reset must match the head of the queue.
    always @(negedge clock) begin
        if (reset === 1'b0 && wen_o !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", rd_o, wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("write_port", {62'd0, pipe_stall_o, rd_o, wdata_o},
                            {62'd0, mon_e.stall, mon_e.rd, mon_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        rs1_i       = '0;
        rs2_i       = '0;
        rf_rdata1_i = '0;
        rf_rdata2_i = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("reset_wen", wen_o, 0);
        checkOutput("reset_ready", mdu_ready_o, 0);
        checkOutput("reset_stall", pipe_stall_o, 0);
        nextCycle();

        // Idle drain of a single MDU result
        reset = 1'b0;
        rs1_i = 5'd7;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        @(negedge clock);
        checkOutput("drain_busy_pre", busy_rs1_o, 0);
        nextCycle();
        expectWrite(7, 64'h2A, 0);
        applyStimulus(0, 0, 0, 1, 7, 64'h2A, 0, 0);
        @(negedge clock);
        checkOutput("drain_ready", mdu_ready_o, 1);
        checkOutput("drain_busy_set", busy_rs1_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("drain_busy_held", busy_rs1_o, 1);
        nextCycle();
        @(negedge clock);
        checkOutput("drain_busy_clr", busy_rs1_o, 0);
        nextCycle();

        // Pipeline priority with starvation force
        rs2_i = 5'd9;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 9, 64'h99, 0, 0);
        nextCycle();
        expectWrite(3, 64'h31, 0);
        applyStimulus(1, 3, 64'h31, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("prio_ready_full", mdu_ready_o, 0);
        nextCycle();
        expectWrite(3, 64'h32, 0);
        applyStimulus(1, 3, 64'h32, 0, 0, 0, 0, 0);
        nextCycle();
        expectWrite(3, 64'h33, 0);
        applyStimulus(1, 3, 64'h33, 0, 0, 0, 0, 0);
        nextCycle();
        expectWrite(9, 64'h99, 1);
        applyStimulus(1, 3, 64'h34, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("force_busy", busy_rs2_o, 1);
        nextCycle();
        expectWrite(3, 64'h34, 0);
        @(negedge clock);
        checkOutput("force_busy_clr", busy_rs2_o, 0);
        checkOutput("force_ready_back", mdu_ready_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Scoreboard set/clear race on the same register
        rs1_i = 5'd12;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 12, 64'hC0, 0, 0);
        nextCycle();
        expectWrite(12, 64'hC0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 12, 64'hC1, 0, 0);
        @(negedge clock);
        checkOutput("race_busy_kept", busy_rs1_o, 1);
        nextCycle();
        expectWrite(12, 64'hC1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        @(negedge clock);
        checkOutput("race_busy_clr", busy_rs1_o, 0);
        nextCycle();

        // x0 pipeline writes do not claim the port; x0 issue sets nothing
        rs1_i = 5'd4;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 4, 64'h44, 0, 0);
        nextCycle();
        expectWrite(4, 64'h44, 0);
        applyStimulus(1, 0, 64'hFF, 0, 0, 0, 1, 0);
        @(negedge clock);
        checkOutput("rd0_busy_set", busy_rs1_o, 1);
        checkOutput("rd0_no_stall", pipe_stall_o, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("rd0_busy_clr", busy_rs1_o, 0);
        nextCycle();

        // Operand forwarding (or pass-through without the macro)
`ifdef WB_FWD_EN
        fwd_expect = 64'hDEAD;
`else
        fwd_expect = 64'h0;
`endif
        rs1_i       = 5'd10;
        rs2_i       = 5'd11;
        rf_rdata1_i = 64'h0;
        rf_rdata2_i = 64'h55;
        expectWrite(10, 64'hDEAD, 0);
        applyStimulus(1, 10, 64'hDEAD, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("fwd_rdata1", rdata1_o, fwd_expect);
        checkOutput("fwd_rdata2", rdata2_o, 64'h55);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("fwd_none_rdata1", rdata1_o, 64'h0);
        nextCycle();

        // Reset while a buffered result is being held off
        rs1_i = 5'd5;
        rs2_i = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 5, 64'h5555, 0, 0);
        nextCycle();
        expectWrite(3, 64'h77, 0);
        applyStimulus(1, 3, 64'h77, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("hold_ready", mdu_ready_o, 0);
        checkOutput("hold_busy", busy_rs1_o, 1);
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("midrst_wen", wen_o, 0);
        checkOutput("midrst_ready", mdu_ready_o, 0);
        checkOutput("midrst_busy", busy_rs1_o, 0);
        nextCycle();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("postrst_ready", mdu_ready_o, 1);
        checkOutput("postrst_busy", busy_rs1_o, 0);
        checkOutput("postrst_wen", wen_o, 0);
        nextCycle();
        @(negedge clock);
        checkOutput("postrst_wen_next", wen_o, 0);
        nextCycle();

        checkOutput("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
